// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a bit stream and
// presents each on a valid/ready port backed by a one-word holding register.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             direction,
  input  logic             sync,
  input  logic             ready,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] parallel_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             word_start;
  logic             eff_dir;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  // A bit arriving with sync starts a fresh word, so it shifts into zero and
  // takes its direction from the port rather than the latched dir_q.
  assign word_start = sync || (cnt_q == '0);
  assign eff_dir    = word_start ? direction : dir_q;
  assign base       = sync ? '0 : sh_q;
  assign shifted    = eff_dir ? {in, base[WIDTH-1:1]} : {base[WIDTH-2:0], in};

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    out_d    = out_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q && !clear_ovf;
    complete = 1'b0;

    if (sync) begin
      sh_d  = '0;
      cnt_d = '0;
    end

    if (en) begin
      sh_d  = shifted;
      dir_d = eff_dir;
      if (sync) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    // The holding register is free if empty or being consumed this cycle;
    // a drop sets overflow even when clear_ovf is asserted alongside it.
    if (complete) begin
      if (!valid_q || ready) begin
        out_d   = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign parallel_out = out_q;
  assign valid        = valid_q;
  assign overflow     = ovf_q;
  assign busy         = (cnt_q != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer (WIDTH=8); inputs change
// 1 time unit after each rising edge and outputs are compared at that point.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in = 1'b0;
  logic       direction = 1'b0;
  logic       sync = 1'b0;
  logic       ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [7:0] parallel_out;
  logic       valid;
  logic       overflow;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_deserializer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in           (in),
    .direction    (direction),
    .sync         (sync),
    .ready        (ready),
    .clear_ovf    (clear_ovf),
    .parallel_out (parallel_out),
    .valid        (valid),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends w MSB-first with en held high, then drops en.
  task automatic send_word(input logic [7:0] w, input logic d);
    for (int i = 7; i >= 0; i--) begin
      en        = 1'b1;
      in        = w[i];
      direction = d;
      tick();
    end
    en = 1'b0;
  endtask

  logic [7:0] seq_a5;
  logic [6:0] tail;

  initial begin
    seq_a5 = 8'hA5;
    tail   = 7'b0110010;

    // Reset state
    tick();
    tick();
    check("rst_data", parallel_out, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    tick();

    // Reset mid-word with a held word present
    send_word(8'h5A, 1'b0);
    check("held_5a", parallel_out, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      in = 1'b1;
      tick();
    end
    en = 1'b0;
    check("mid_busy", {7'd0, busy}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", parallel_out, 8'h00);
    check("async_rst_valid", {7'd0, valid}, 8'd0);
    check("async_rst_busy", {7'd0, busy}, 8'd0);
    #1 rst = 1'b0;
    tick();
    ready = 1'b1;
    send_word(8'h96, 1'b0);
    check("post_rst_valid", {7'd0, valid}, 8'd1);
    check("post_rst_word", parallel_out, 8'h96);

    // direction=0, bits 1,0,1,0,0,1,0,1 with busy tracking
    tick();
    check("idle_valid", {7'd0, valid}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    for (int i = 7; i >= 0; i--) begin
      en        = 1'b1;
      in        = seq_a5[i];
      direction = 1'b0;
      tick();
      if (i > 0) begin
        check($sformatf("busy_bit%0d", 9 - i), {7'd0, busy}, 8'd1);
        check($sformatf("novalid_bit%0d", 8 - i), {7'd0, valid}, 8'd0);
      end
    end
    en = 1'b0;
    check("a5_valid", {7'd0, valid}, 8'd1);
    check("a5_word", parallel_out, 8'hA5);
    check("a5_busy_done", {7'd0, busy}, 8'd0);
    tick();
    check("a5_pulse_end", {7'd0, valid}, 8'd0);

    // direction=1, toggled to 0 after bit 3 (latched dir ignores it)
    for (int i = 7; i >= 0; i--) begin
      en        = 1'b1;
      in        = seq_a5[i];
      direction = (i >= 5);
      tick();
    end
    en = 1'b0;
    check("dir1_valid", {7'd0, valid}, 8'd1);
    check("dir1_word", parallel_out, 8'hA5);
    tick();
    send_word(8'h12, 1'b1);
    check("dir1_rev_word", parallel_out, 8'h48);
    tick();
    check("dir1_rev_clear", {7'd0, valid}, 8'd0);

    // Backpressure and overflow
    ready = 1'b0;
    send_word(8'h3C, 1'b0);
    check("bp_valid", {7'd0, valid}, 8'd1);
    check("bp_word", parallel_out, 8'h3C);
    send_word(8'hC3, 1'b0);
    check("bp_ovf", {7'd0, overflow}, 8'd1);
    check("bp_word_kept", parallel_out, 8'h3C);
    check("bp_valid_kept", {7'd0, valid}, 8'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_consumed", {7'd0, valid}, 8'd0);
    check("bp_ovf_sticky", {7'd0, overflow}, 8'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", {7'd0, overflow}, 8'd0);

    // Drop and clear_ovf in the same cycle: set wins
    send_word(8'h01, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      en        = 1'b1;
      in        = i[0];
      clear_ovf = (i == 0);
      tick();
    end
    en        = 1'b0;
    clear_ovf = 1'b0;
    check("set_wins_ovf", {7'd0, overflow}, 8'd1);
    check("set_wins_word", parallel_out, 8'h01);
    ready     = 1'b1;
    clear_ovf = 1'b1;
    tick();
    ready     = 1'b0;
    clear_ovf = 1'b0;
    check("flush_valid", {7'd0, valid}, 8'd0);

    // Simultaneous consume and complete
    send_word(8'h11, 1'b0);
    check("sim_hold", parallel_out, 8'h11);
    for (int i = 7; i >= 0; i--) begin
      en    = 1'b1;
      in    = (i == 5) || (i == 1);
      ready = (i == 0);
      tick();
    end
    en    = 1'b0;
    ready = 1'b0;
    check("sim_ovf", {7'd0, overflow}, 8'd0);
    check("sim_valid", {7'd0, valid}, 8'd1);
    check("sim_word", parallel_out, 8'h22);
    ready = 1'b1;
    tick();
    check("sim_drain", {7'd0, valid}, 8'd0);

    // sync mid-word: 5 bits, sync with in=1, then 7 bits -> 8'hB2
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      in = 1'b1;
      tick();
    end
    sync = 1'b1;
    in   = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_valid", {7'd0, valid}, 8'd0);
    check("sync_busy", {7'd0, busy}, 8'd1);
    for (int i = 6; i >= 0; i--) begin
      in = tail[i];
      tick();
      if (i > 0) check($sformatf("sync_novalid_%0d", 7 - i), {7'd0, valid}, 8'd0);
    end
    en = 1'b0;
    check("sync_word_valid", {7'd0, valid}, 8'd1);
    check("sync_word", parallel_out, 8'hB2);
    check("sync_ovf", {7'd0, overflow}, 8'd0);
    tick();
    check("sync_drain", {7'd0, valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive-side counterpart of shift_register: collects a serial bit stream produced by a shift_register in serialising mode and reassembles WIDTH-bit words.
- Each completed word is presented on a valid/ready output port backed by a one-word holding register.
- Words that arrive while the holding register is still occupied are dropped, and the drop is flagged with a sticky overflow bit.
- Sits between a serial link and the parallel consumer logic.

Parameters:
- WIDTH, 8, word length in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit strobe; `in` is sampled only on cycles where en=1.
- in  input  1  serial data bit.
- direction  input  1  0 = new bit enters at bit 0 (shift toward MSB); 1 = new bit enters at bit WIDTH-1 (shift toward LSB).
- sync  input  1  word-alignment restart; discards any partial word.
- ready  input  1  consumer accepts the presented word.
- clear_ovf  input  1  clears the sticky overflow flag.
- parallel_out  output  WIDTH  holding-register contents (the presented word).
- valid  output  1  parallel_out holds an unconsumed word.
- overflow  output  1  sticky flag: a completed word was dropped.
- busy  output  1  partial word in progress (bit counter != 0).

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately:
  - shift register sh = 0, bit counter cnt = 0, latched direction dir_q = 0;
  - parallel_out = 0, valid = 0, overflow = 0, busy = 0.
  - Reset asserted mid-word discards the partial word and any held word.
- Bit capture, on a cycle with en=1:
  - If cnt==0: dir_q <= direction, and the current bit is shifted using `direction` itself.
  - Otherwise the bit is shifted using dir_q. Direction changes mid-word are therefore ignored until the next word.
  - Shift with dir=0: sh <= {sh[WIDTH-2:0], in}.
  - Shift with dir=1: sh <= {in, sh[WIDTH-1:1]}.
  - cnt increments and wraps from WIDTH-1 to 0.
- en=0: sh, cnt and dir_q hold.
- Word completion occurs on an en=1 cycle with cnt==WIDTH-1. The completed word is the shifted value including the current bit.
  - If the holding register is free (valid=0, or valid=1 with ready=1 this cycle), parallel_out <= completed word and valid=1 from the next cycle. Latency from the last bit's en edge to valid is 1 cycle.
  - Otherwise the word is dropped, parallel_out is unchanged, and overflow <= 1.
  - sh is not cleared on completion; it is simply overwritten by the following bits.
- Output handshake:
  - A transfer occurs on a cycle with valid=1 and ready=1.
  - After a transfer, valid clears next cycle unless a new word completes the same cycle, in which case valid stays 1 and parallel_out updates.
  - While valid=1 and ready=0, parallel_out and valid are held stable.
  - ready is ignored while valid=0.
- sync=1:
  - cnt <= 0 and sh <= 0. The partial word is discarded and no overflow is raised.
  - If en=1 in the same cycle, the bit is taken as bit 1 of a new word: cnt <= 1, dir_q <= direction, and sh receives the bit shifted into a zero register.
  - sync does not affect parallel_out, valid or overflow.
- overflow:
  - Set on a dropped word; remains set until clear_ovf=1 or reset.
  - If a drop and clear_ovf=1 occur in the same cycle, set wins (overflow=1).
- busy = (cnt != 0), driven combinationally from the registered cnt.

Test Plan:
- Reset mid-word: 3 en bits with in=1, then pulse rst between clock edges.
  - Required: parallel_out=8'h00, valid=0, busy=0 immediately.
  - A following 8-bit word is assembled correctly from bit 0.
- direction=0, en=1 continuously, serial bits 1,0,1,0,0,1,0,1 (first bit first), ready=1.
  - Required: valid pulses for exactly 1 cycle, one cycle after the 8th bit, with parallel_out=8'hA5.
  - busy=1 during bits 2-8.
- direction=1, same bit sequence.
  - Required: parallel_out=8'hA5 reversed, i.e. 8'hA5 with first bit at LSB.
  - Toggle direction to 0 after bit 3: result is unchanged because dir_q is latched.
- Backpressure, ready=0: send word 8'h3C, then word 8'hC3.
  - Required: after the first word, valid=1 and parallel_out=8'h3C holds.
  - The second word sets overflow=1; parallel_out stays 8'h3C.
  - Raising ready for 1 cycle gives valid=0 next cycle.
  - clear_ovf=1 gives overflow=0.
- Simultaneous consume and complete: hold word 8'h11 with ready=0, then raise ready on the exact cycle the last bit of word 8'h22 arrives.
  - Required: no overflow; valid stays 1; parallel_out=8'h22 next cycle.
- sync mid-word: after 5 bits assert sync with en=1 and in=1, then send 7 more bits.
  - Required: no valid after the discarded partial word; one valid word formed from the sync-cycle bit plus the 7 bits; overflow=0.
